rob_commit: RTL and testbench
=============================

ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 The module SHALL have parameter FLUSH_CYCLES, default 2, the number of cycles the FLUSH state is held (minimum 1).
REQ-002 The module SHALL have parameter CNT_W, default 32, the width of the retired-instruction counter.
REQ-003 The module SHALL have one clock, clk_i, and reset_i, which is asynchronous and active-low.
REQ-004 clk_i  in  1  rising-edge clock.
REQ-005 reset_i  in  1  asynchronous active-low reset.
REQ-006 commitReadData_i  in  77  ROB head entry: [76] valid, [75] regWrite, [74:70] rd, [69:67] reserved, [66] exception, [65] mispredict, [64] done, [63:0] result.
REQ-007 halt_i  in  1  debug hold; no retirement while high.
REQ-008 updateHead_o  out  1  pop ROB head this cycle.
REQ-009 rfWriteEn_o, rfWriteAddr_o, rfWriteData_o  out  1/5/64  architectural register-file write port.
REQ-010 flush_o  out  1  pipeline flush request.
REQ-011 exception_o  out  1  sticky exception halt flag.
REQ-012 retired_o  out  CNT_W  retired-instruction count.

Function
REQ-013 The FSM SHALL have three states, RUN, FLUSH and HALT.
REQ-014 An entry is "ready" when valid & done.
REQ-015 In RUN with halt_i low and head ready, updateHead_o SHALL be 1 combinationally in the same cycle; otherwise it SHALL be 0.
REQ-016 updateHead_o SHALL be 0 in FLUSH and HALT.
REQ-017 Retirement SHALL be at most one entry per cycle.
REQ-018 A retiring entry with regWrite=1 and rd!=0 SHALL produce rfWriteEn_o=1, rfWriteAddr_o=rd and rfWriteData_o=result one cycle after updateHead_o (registered); otherwise rfWriteEn_o SHALL be 0 that cycle.
REQ-019 rd=0 writes SHALL be suppressed.
REQ-020 Retiring a mispredict entry SHALL perform its RF write if applicable, pulse flush_o for exactly one cycle (the cycle after retirement), move to FLUSH, stay FLUSH_CYCLES cycles via a down-counter, then return to RUN.
REQ-021 A ready exception entry SHALL NOT retire: updateHead_o=0, no RF write, the FSM enters HALT next cycle, exception_o is set to 1 and is held until reset; retired_o SHALL NOT increment.
REQ-022 If both exception and mispredict are set, exception SHALL take priority.
REQ-023 retired_o SHALL increment by 1 per updateHead_o pulse, wrap modulo 2^CNT_W, and be visible the following cycle.
REQ-024 A not-ready or invalid head (including empty ROB) SHALL leave all outputs idle with no state change.
REQ-025 halt_i asserted in FLUSH SHALL NOT stop the flush counter; on return to RUN, retirement SHALL be gated by halt_i.

Reset
REQ-026 While reset_i=0: state=RUN, flush counter=0, rfWriteEn_o=0, rfWriteAddr_o=0, rfWriteData_o=0, flush_o=0, exception_o=0, retired_o=0, and updateHead_o=0 regardless of the head entry.
REQ-027 Reset asserted mid-FLUSH or in HALT SHALL return the block to RUN immediately (asynchronously); the first retirement SHALL be possible in the first cycle after deassertion.

Structure
REQ-028 A shared package SHALL hold: the commit entry field bit positions, a typedef for the 77-bit entry, the state enum, and constants ROB_ENTRY_W=77, RF_ADDR_W=5 and XLEN=64.
REQ-029 The retired-instruction counter SHALL be a sub-module named commit_counter (CNT_W, enable, asynchronous active-low reset); everything else is inline.

Verification
REQ-030 Reset then head {valid=1, done=1, regWrite=1, rd=7, result=0xDEAD} -> updateHead_o=1 same cycle; next cycle rfWriteEn_o=1, rfWriteAddr_o=7, rfWriteData_o=0xDEAD, retired_o=1.
REQ-031 Head valid=1, done=0 for 3 cycles, then done=1 -> updateHead_o=0 for 3 cycles, then 1; rfWriteEn_o only after the done cycle.
REQ-032 Head mispredict=1, regWrite=0, FLUSH_CYCLES=2 -> updateHead_o one cycle, flush_o one cycle, updateHead_o=0 for 2 cycles with a ready head present, then retirement resumes.
REQ-033 Head exception=1, done=1 -> updateHead_o never asserted, exception_o=1 from the next cycle and held 10+ cycles, retired_o unchanged; reset_i=0 clears it.
REQ-034 Head regWrite=1, rd=0 -> updateHead_o=1, rfWriteEn_o=0, retired_o+1.
REQ-035 CNT_W=4, 17 back-to-back ready entries -> retired_o wraps to 1; halt_i=1 mid-stream stops updateHead_o in the same cycle.

Source files
------------

// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: commit entry layout, FSM states and datapath widths shared by the commit stage.
package rob_commit_pkg;
  localparam int ROB_ENTRY_W = 77;
  localparam int RF_ADDR_W = 5;
  localparam int XLEN = 64;
  localparam int VALID_BIT = 76;
  localparam int REGWRITE_BIT = 75;
  localparam int RD_HI = 74;
  localparam int RD_LO = 70;
  localparam int RSVD_HI = 69;
  localparam int RSVD_LO = 67;
  localparam int EXCEPTION_BIT = 66;
  localparam int MISPREDICT_BIT = 65;
  localparam int DONE_BIT = 64;
  localparam int RESULT_HI = 63;
  localparam int RESULT_LO = 0;
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic [RF_ADDR_W-1:0] rd;
    logic [2:0] rsvd;
    logic exception;
    logic mispredict;
    logic done;
    logic [XLEN-1:0] result;
  } commit_entry_t;
  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
endpackage

// File: rtl/rob_commit_if.sv
// rob_commit_if: ROB head / register-file / status bundle between the ROB side and the commit stage.
interface rob_commit_if
  import rob_commit_pkg::*;
#(parameter int CNT_W = 32);
  commit_entry_t commitReadData_i;
  logic halt_i;
  logic updateHead_o;
  logic rfWriteEn_o;
  logic [RF_ADDR_W-1:0] rfWriteAddr_o;
  logic [XLEN-1:0] rfWriteData_o;
  logic flush_o;
  logic exception_o;
  logic [CNT_W-1:0] retired_o;
  modport master (
    output commitReadData_i, halt_i,
    input updateHead_o, rfWriteEn_o, rfWriteAddr_o, rfWriteData_o, flush_o, exception_o, retired_o
  );
  modport slave (
    input commitReadData_i, halt_i,
    output updateHead_o, rfWriteEn_o, rfWriteAddr_o, rfWriteData_o, flush_o, exception_o, retired_o
  );
endinterface

// File: rtl/rob_commit_counter.sv
// commit_counter: wrapping retired-instruction counter.
module commit_counter #(
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (en) count <= count + 1'b1;
endmodule

// File: rtl/rob_commit.sv
// rob_commit: in-order retirement of the ROB head with mispredict flush and sticky exception halt.
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 32
) (
  input logic clk_i,
  input logic reset_i,
  rob_commit_if.slave bus
);
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  state_t state, state_nxt;
  logic [FC_W-1:0] fcnt;
  commit_entry_t e;
  logic go, retire, take_exc, do_flush, rf_we, unused_rsvd;
  assign e = bus.commitReadData_i;
  assign unused_rsvd = ^e.rsvd;
  // reset_i in the gate keeps updateHead_o low while reset is held
  assign go = reset_i & (state == RUN) & ~bus.halt_i & e.valid & e.done;
  assign take_exc = go & e.exception;
  assign retire = go & ~e.exception;
  assign do_flush = retire & e.mispredict;
  assign rf_we = retire & e.reg_write & (|e.rd);
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) state <= RUN;
    else state <= state_nxt;
  always_comb
    state_nxt = take_exc ? HALT :
                do_flush ? FLUSH :
                (state == FLUSH && fcnt == '0) ? RUN : state;
  always_comb
    bus.updateHead_o = retire;
  // loaded with FLUSH_CYCLES-1 so FLUSH lasts exactly FLUSH_CYCLES cycles
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) fcnt <= '0;
    else if (do_flush) fcnt <= FC_W'(FLUSH_CYCLES - 1);
    else if (state == FLUSH && fcnt != '0) fcnt <= fcnt - 1'b1;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      bus.rfWriteEn_o <= 1'b0;
      bus.rfWriteAddr_o <= '0;
      bus.rfWriteData_o <= '0;
      bus.flush_o <= 1'b0;
      bus.exception_o <= 1'b0;
    end else begin
      bus.rfWriteEn_o <= rf_we;
      if (rf_we) begin
        bus.rfWriteAddr_o <= e.rd;
        bus.rfWriteData_o <= e.result;
      end
      bus.flush_o <= do_flush;
      bus.exception_o <= bus.exception_o | take_exc;
    end
  commit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk_i),
    .rst_n(reset_i),
    .en(retire),
    .count(bus.retired_o)
  );
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed and randomized checks of rob_commit against a behavioural commit model.
module tb_rob_commit;
  import rob_commit_pkg::*;
  localparam int FC = 2;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  commit_entry_t ent;
  logic halt;
  always #5 clk = ~clk;
  rob_commit_if #(.CNT_W(CW)) bus();
  assign bus.commitReadData_i = ent;
  assign bus.halt_i = halt;
  rob_commit #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk_i(clk),
    .reset_i(reset_n),
    .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  int flush_left, ret_cnt, saved_ret;
  bit halted, m_exc, m_rfen, m_flush;
  logic [4:0] m_addr;
  logic [63:0] m_data;
  function automatic commit_entry_t mk(bit v, bit d, bit rw, logic [4:0] rd, bit exc, bit misp, logic [63:0] res);
    commit_entry_t x;
    x = '0;
    x.valid = v; x.done = d; x.reg_write = rw; x.rd = rd;
    x.exception = exc; x.mispredict = misp; x.result = res;
    return x;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic bit can_act();
    return reset_n && !halted && flush_left == 0 && !halt && ent.valid && ent.done;
  endfunction
  function automatic bit exp_uh();
    return can_act() && !ent.exception;
  endfunction
  task automatic model_reset();
    flush_left = 0; ret_cnt = 0; halted = 0; m_exc = 0;
    m_rfen = 0; m_flush = 0; m_addr = '0; m_data = '0;
  endtask
  task automatic model_clock();
    bit uh, ex;
    uh = exp_uh();
    ex = can_act() && ent.exception;
    if (flush_left > 0) flush_left--;
    m_rfen = uh && ent.reg_write && ent.rd != 0;
    if (m_rfen) begin
      m_addr = ent.rd;
      m_data = ent.result;
    end
    m_flush = uh && ent.mispredict;
    if (m_flush) flush_left = FC;
    if (uh) ret_cnt = (ret_cnt + 1) % (1 << CW);
    if (ex) begin
      halted = 1;
      m_exc = 1;
    end
  endtask
  task automatic look();
    @(negedge clk);
    chk("updateHead", bus.updateHead_o, exp_uh());
    chk("rfWriteEn", bus.rfWriteEn_o, m_rfen);
    if (m_rfen) begin
      chk("rfWriteAddr", bus.rfWriteAddr_o, m_addr);
      chk("rfWriteData", bus.rfWriteData_o, m_data);
    end
    chk("flush", bus.flush_o, m_flush);
    chk("exception", bus.exception_o, m_exc);
    chk("retired", bus.retired_o, 64'(ret_cnt));
  endtask
  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask
  // asserted away from the clock edge; outputs must clear without a clock
  task automatic do_reset();
    reset_n = 1'b0;
    halt = 1'b0;
    ent = mk(1, 1, 1, 5'd9, 0, 0, 64'h55);
    #1;
    chk("rst_updateHead", bus.updateHead_o, 0);
    chk("rst_rfWriteEn", bus.rfWriteEn_o, 0);
    chk("rst_rfWriteAddr", bus.rfWriteAddr_o, 0);
    chk("rst_rfWriteData", bus.rfWriteData_o, 0);
    chk("rst_flush", bus.flush_o, 0);
    chk("rst_exception", bus.exception_o, 0);
    chk("rst_retired", bus.retired_o, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ent = '0;
  endtask
  initial begin
    halt = 1'b0;
    ent = '0;
    model_reset();
    #3;
    do_reset();
    ent = mk(1, 1, 1, 5'd7, 0, 0, 64'hDEAD);
    look(); chk("t1_uh", bus.updateHead_o, 1); tick();
    ent = '0;
    look();
    chk("t1_en", bus.rfWriteEn_o, 1); chk("t1_addr", bus.rfWriteAddr_o, 7);
    chk("t1_data", bus.rfWriteData_o, 64'hDEAD); chk("t1_ret", bus.retired_o, 1);
    tick();
    ent = mk(1, 0, 1, 5'd3, 0, 0, 64'h1234);
    repeat (3) begin
      look(); chk("t2_uh_wait", bus.updateHead_o, 0); chk("t2_en_wait", bus.rfWriteEn_o, 0); tick();
    end
    ent.done = 1'b1;
    look(); chk("t2_uh", bus.updateHead_o, 1); tick();
    ent = '0;
    look(); chk("t2_en", bus.rfWriteEn_o, 1); chk("t2_ret", bus.retired_o, 2); tick();
    ent = mk(1, 1, 0, 5'd4, 0, 1, 64'h0);
    look(); chk("t3_uh", bus.updateHead_o, 1); tick();
    ent = mk(1, 1, 1, 5'd5, 0, 0, 64'hBEEF);
    look(); chk("t3_flush", bus.flush_o, 1); chk("t3_uh_f1", bus.updateHead_o, 0); tick();
    look(); chk("t3_flush_off", bus.flush_o, 0); chk("t3_uh_f2", bus.updateHead_o, 0); tick();
    look(); chk("t3_resume", bus.updateHead_o, 1); tick();
    ent = mk(1, 1, 0, 5'd1, 0, 1, 64'h0);
    look(); tick();
    ent = mk(1, 1, 1, 5'd0, 0, 0, 64'h77);
    look(); chk("t4_inflush", bus.updateHead_o, 0);
    do_reset();
    ent = mk(1, 1, 1, 5'd0, 0, 0, 64'h77);
    look(); chk("t4_uh_after_rst", bus.updateHead_o, 1); tick();
    ent = '0;
    look(); chk("t4_rd0_en", bus.rfWriteEn_o, 0); chk("t4_ret", bus.retired_o, 1); tick();
    saved_ret = ret_cnt;
    ent = mk(1, 1, 1, 5'd6, 1, 1, 64'h99);
    look(); chk("t5_uh", bus.updateHead_o, 0); tick();
    ent = mk(1, 1, 1, 5'd6, 0, 0, 64'h99);
    repeat (12) begin
      look(); chk("t5_exc", bus.exception_o, 1); chk("t5_uh_halt", bus.updateHead_o, 0);
      chk("t5_en", bus.rfWriteEn_o, 0); chk("t5_ret", bus.retired_o, 64'(saved_ret)); tick();
    end
    do_reset();
    for (int i = 0; i < 17; i++) begin
      ent = mk(1, 1, 1, 5'(i + 1), 0, 0, 64'(i * 3));
      look(); tick();
    end
    ent = mk(1, 1, 1, 5'd2, 0, 0, 64'h5);
    look(); chk("t6_wrap", bus.retired_o, 1);
    tick();
    halt = 1'b1;
    look(); chk("t6_halt", bus.updateHead_o, 0); tick();
    halt = 1'b0;
    look(); chk("t6_unhalt", bus.updateHead_o, 1); tick();
    for (int n = 0; n < 3000; n++) begin
      ent = mk($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 1),
               5'($urandom_range(0, 31)), $urandom_range(0, 99) < 3, $urandom_range(0, 9) == 0,
               {32'($urandom), 32'($urandom)});
      ent.rsvd = 3'($urandom_range(0, 7));
      halt = $urandom_range(0, 99) < 15;
      look();
      if ((halted && $urandom_range(0, 19) == 0) || $urandom_range(0, 499) == 0) do_reset();
      else tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
